// File: rtl/apb_slv_memory_ws.sv
// APB4 slave memory with a programmable wait-state count, byte-strobe writes and PSLVERR on bad accesses.
// Optional write protection of the low WPROT_LIMIT words is enabled by defining APB_MEM_WPROT_EN.
module apb_slv_memory_ws #(
    parameter int DATA_SIZE   = 32,
    parameter int ADDR_SIZE   = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2,
    parameter int WPROT_LIMIT = 4
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic [ADDR_SIZE-1:0]   PADDR,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [DATA_SIZE-1:0]   PWDATA,
    input  logic [DATA_SIZE/8-1:0] PSTROBE,
    output logic                   PREADY,
    output logic [DATA_SIZE-1:0]   PRDATA,
    output logic                   PSLVERR
);

    localparam int NUM_LANES = DATA_SIZE / 8;
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef APB_MEM_WPROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [3:0]           r_cnt;
    logic [3:0]           w_nextCnt;
    logic                 w_eval;
    logic                 w_commit;
    logic                 w_outOfRange;
    logic                 w_err;
    logic [IDX_W-1:0]     w_idx;
    logic                 r_pready;
    logic                 r_pslverr;
    logic [DATA_SIZE-1:0] r_prdata;
    logic [DATA_SIZE-1:0] r_mem [DEPTH];

    assign w_idx        = PADDR[IDX_W-1:0];
    assign w_outOfRange = 32'(PADDR) >= 32'(DEPTH);
    assign w_err        = w_outOfRange | (PROT_EN & PWRITE & (32'(PADDR) < 32'(WPROT_LIMIT)));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // A fresh setup phase in WAIT restarts the wait count; dropping PSEL abandons the transfer.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_eval      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_nextState = S_WAIT;
                    w_nextCnt   = 4'(WAIT_STATES);
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    w_nextState = S_IDLE;
                end else if (!PENABLE) begin
                    w_nextCnt = 4'(WAIT_STATES);
                end else if (r_cnt != 4'd0) begin
                    w_nextCnt = r_cnt - 4'd1;
                end else begin
                    w_nextState = S_DONE;
                    w_eval      = 1'b1;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
                w_commit    = PSEL & PENABLE & PWRITE & ~r_pslverr;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Response is latched when the wait count expires so it is stable for the whole PREADY cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            r_pready  <= w_eval;
            r_pslverr <= w_eval & w_err;
            if (w_eval) begin
                r_prdata <= (!w_err && !PWRITE) ? r_mem[w_idx] : '0;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_commit) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (PSTROBE[i]) begin
                    r_mem[w_idx][8*i +: 8] <= PWDATA[8*i +: 8];
                end
            end
        end
    end

    assign PREADY  = r_pready;
    assign PSLVERR = r_pslverr;
    assign PRDATA  = r_prdata;

endmodule
